// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: dmem req/ack, stall, store formatting, load extension
module mem_stage_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_EX,
  input  logic        regwrite_EX,
  input  logic [4:0]  rd_EX,
  input  logic        memread_EX,
  input  logic        memwrite_EX,
  input  logic [2:0]  funct3_EX,
  input  logic [31:0] ALU_data_EX,
  input  logic [31:0] store_data_EX,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        regwrite_MEM,
  output logic [4:0]  rd_MEM,
  output logic        memread_MEM,
  output logic [31:0] ALU_data_MEM,
  output logic [31:0] mem_data_MEM,
  output logic        stall_MEM,
  output logic        misalign_MEM,
  output logic        bus_err_MEM
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]    dmem_be_q, dmem_be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          memop;
  logic          fault;
  logic [31:0]   wdata_fmt;
  logic [3:0]    be_fmt;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  assign memop = valid_EX & (memread_EX | memwrite_EX);

  // Illegal sizes and unaligned accesses never reach the bus
  always_comb begin
    fault = 1'b0;
    case (funct3_EX)
      3'b000:  fault = 1'b0;
      3'b001:  fault = ALU_data_EX[0];
      3'b010:  fault = |ALU_data_EX[1:0];
      3'b100:  fault = memwrite_EX;
      3'b101:  fault = memwrite_EX | ALU_data_EX[0];
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    wdata_fmt = store_data_EX;
    be_fmt    = 4'b1111;
    case (funct3_EX[1:0])
      2'b00: begin
        wdata_fmt = {4{store_data_EX[7:0]}};
        be_fmt    = 4'b0001 << ALU_data_EX[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{store_data_EX[15:0]}};
        be_fmt    = ALU_data_EX[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_fmt = store_data_EX;
        be_fmt    = 4'b1111;
      end
    endcase
  end

  assign byte_sel = rdata_q[{ALU_data_EX[1:0], 3'b000} +: 8];
  assign half_sel = ALU_data_EX[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    load_ext = rdata_q;
    case (funct3_EX)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    stall_MEM    = 1'b0;
    misalign_MEM = 1'b0;
    mem_data_MEM = 32'h0;
    case (state_q)
      IDLE: begin
        if (memop && fault) begin
          misalign_MEM = 1'b1;
        end else if (memop) begin
          stall_MEM    = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = memwrite_EX;
          dmem_addr_d  = {ALU_data_EX[31:2], 2'b00};
          dmem_wdata_d = wdata_fmt;
          dmem_be_d    = be_fmt;
          cnt_d        = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        stall_MEM = 1'b1;
        // An ack in the final timeout cycle still completes normally
        if (dmem_ack) begin
          rdata_d    = dmem_rdata;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          state_d    = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          err_d      = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        mem_data_MEM = load_ext;
        err_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_wdata_q <= 32'h0;
      dmem_be_q    <= 4'h0;
      cnt_q        <= '0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_be      = dmem_be_q;
  assign bus_err_MEM  = (state_q == DONE) & err_q;
  assign rd_MEM       = rd_EX;
  assign ALU_data_MEM = ALU_data_EX;
  assign memread_MEM  = memread_EX & valid_EX;
  assign regwrite_MEM = regwrite_EX & valid_EX & ~stall_MEM & ~misalign_MEM & ~bus_err_MEM;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed plus randomized transaction-level checks of mem_stage_lsu
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_EX, regwrite_EX, memread_EX, memwrite_EX;
  logic [4:0]  rd_EX;
  logic [2:0]  funct3_EX;
  logic [31:0] ALU_data_EX, store_data_EX;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        regwrite_MEM, memread_MEM, stall_MEM, misalign_MEM, bus_err_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] ALU_data_MEM, mem_data_MEM;

  int checks = 0;
  int errors = 0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .valid_EX(valid_EX), .regwrite_EX(regwrite_EX),
    .rd_EX(rd_EX), .memread_EX(memread_EX), .memwrite_EX(memwrite_EX),
    .funct3_EX(funct3_EX), .ALU_data_EX(ALU_data_EX), .store_data_EX(store_data_EX),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .regwrite_MEM(regwrite_MEM), .rd_MEM(rd_MEM), .memread_MEM(memread_MEM),
    .ALU_data_MEM(ALU_data_MEM), .mem_data_MEM(mem_data_MEM), .stall_MEM(stall_MEM),
    .misalign_MEM(misalign_MEM), .bus_err_MEM(bus_err_MEM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return (a % 2) != 0;
      3'd2:    return (a % 4) != 0;
      3'd4:    return st;
      3'd5:    return st || ((a % 2) != 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    int off = (a % 4) / sz * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    int off = a % 4;
    longint b = (r >> (8 * off)) % 256;
    longint h = (r >> (16 * ((a % 4) / 2))) % 65536;
    case (f3)
      3'd0:    return 32'(b - ((b >= 128) ? 256 : 0));
      3'd1:    return 32'(h - ((h >= 32768) ? 65536 : 0));
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return r;
    endcase
  endfunction

  task automatic nonmem(input bit v, input bit rw, input logic [4:0] rd, input logic [31:0] alu);
    valid_EX = v; regwrite_EX = rw; rd_EX = rd; memread_EX = 0; memwrite_EX = 0;
    ALU_data_EX = alu; dmem_ack = 0;
    #1;
    chk("alu_stall", stall_MEM, 0);
    chk("alu_regwrite", regwrite_MEM, v & rw);
    chk("alu_rd", rd_MEM, rd);
    chk("alu_data", ALU_data_MEM, alu);
    chk("alu_memdata", mem_data_MEM, 0);
    chk("alu_req", dmem_req, 0);
    @(negedge clk);
  endtask

  // ack_at: BUSY cycle (1..TO) on which ack arrives; 0 means never
  task automatic mem_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd, input bit rw,
                        input int ack_at, input logic [31:0] rdat);
    bit err = (ack_at == 0);
    valid_EX = 1; regwrite_EX = rw; rd_EX = rd; memread_EX = !st; memwrite_EX = st;
    funct3_EX = f3; ALU_data_EX = a; store_data_EX = sd; dmem_ack = 0; dmem_rdata = rdat;
    #1;
    if (ref_fault(st, f3, a)) begin
      chk("flt_misalign", misalign_MEM, 1);
      chk("flt_stall", stall_MEM, 0);
      chk("flt_regwrite", regwrite_MEM, 0);
      chk("flt_req", dmem_req, 0);
      @(negedge clk);
      #1 chk("flt_req_next", dmem_req, 0);
      return;
    end
    chk("issue_stall", stall_MEM, 1);
    chk("issue_misalign", misalign_MEM, 0);
    chk("issue_regwrite", regwrite_MEM, 0);
    chk("memread_MEM", memread_MEM, !st);
    @(negedge clk);
    for (int k = 1; k <= TO; k++) begin
      dmem_ack = (k == ack_at);
      #1;
      chk("busy_stall", stall_MEM, 1);
      chk("busy_req", dmem_req, 1);
      chk("busy_we", dmem_we, st);
      chk("busy_addr", dmem_addr, a - (a % 4));
      chk("busy_be", dmem_be, ref_be(f3, a));
      if (st) chk("busy_wdata", dmem_wdata, ref_wdata(f3, sd));
      chk("busy_regwrite", regwrite_MEM, 0);
      chk("busy_memdata", mem_data_MEM, 0);
      @(negedge clk);
      dmem_ack = 0;
      if (k == ack_at) break;
    end
    #1;
    chk("done_stall", stall_MEM, 0);
    chk("done_req", dmem_req, 0);
    chk("done_bus_err", bus_err_MEM, err);
    chk("done_regwrite", regwrite_MEM, rw & !err);
    if (!st && !err) chk("done_memdata", mem_data_MEM, ref_load(f3, a, rdat));
    @(negedge clk);
  endtask

  logic [2:0] f3_pool [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

  initial begin
    reset = 1; valid_EX = 0; regwrite_EX = 0; rd_EX = 0; memread_EX = 0; memwrite_EX = 0;
    funct3_EX = 0; ALU_data_EX = 0; store_data_EX = 0; dmem_ack = 0; dmem_rdata = 0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_stall", stall_MEM, 0);
    chk("rst_memdata", mem_data_MEM, 0);
    chk("rst_bus_err", bus_err_MEM, 0);
    @(negedge clk);
    reset = 0;

    nonmem(1, 1, 5'd3, 32'h1111_2222);
    mem_op(0, 3'd2, 32'h100, 0, 5'd5, 1, 2, 32'hDEAD_BEEF);
    mem_op(0, 3'd0, 32'h103, 0, 5'd6, 1, 1, 32'h80FF_0000);
    mem_op(0, 3'd4, 32'h103, 0, 5'd7, 1, 1, 32'h80FF_0000);
    mem_op(1, 3'd1, 32'h202, 32'h1234_ABCD, 5'd0, 0, 3, 0);
    mem_op(0, 3'd2, 32'h102, 0, 5'd8, 1, 1, 0);
    mem_op(0, 3'd2, 32'h300, 0, 5'd9, 1, 0, 0);
    mem_op(0, 3'd1, 32'h402, 0, 5'd10, 1, TO, 32'h8001_7FFF);
    nonmem(1, 1, 5'd4, 32'h0);

    valid_EX = 1; regwrite_EX = 1; rd_EX = 5'd11; memread_EX = 1; memwrite_EX = 0;
    funct3_EX = 3'd2; ALU_data_EX = 32'h500; dmem_ack = 0;
    @(negedge clk); @(negedge clk);
    #2 reset = 1;
    #1;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_stall_live", stall_MEM, 1);
    chk("midrst_be", dmem_be, 0);
    valid_EX = 0;
    #1 chk("midrst_stall_idle", stall_MEM, 0);
    @(negedge clk);
    reset = 0; dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    #1 chk("late_ack_req", dmem_req, 0);
    @(negedge clk);
    dmem_ack = 0;
    #1;
    chk("late_ack_memdata", mem_data_MEM, 0);
    chk("late_ack_stall", stall_MEM, 0);
    chk("late_ack_bus_err", bus_err_MEM, 0);
    @(negedge clk);
    nonmem(1, 1, 5'd12, 32'hABCD_0123);

    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      logic [31:0] a = $urandom;
      logic [2:0] f3 = f3_pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if (kind == 0) nonmem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), a);
      else mem_op(kind == 2, f3, a, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, TO), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
